// File: rtl/jump_scheduler_if.sv
// Handshake bundle between the game controller and the jump scheduler.
// The master drives player/game events; the slave returns jump commands and status.
interface jump_scheduler_if;
    logic       en;
    logic [1:0] key_code;
    logic       one_ms_tick;
    logic       landed;
    logic       jump_fail;
    logic       jump_left;
    logic       jump_right;
    logic       busy;
    logic [1:0] queue_count;
    logic       overflow;
    logic       timeout;

    modport master (
        output en, key_code, one_ms_tick, landed, jump_fail,
        input  jump_left, jump_right, busy, queue_count, overflow, timeout
    );

    modport slave (
        input  en, key_code, one_ms_tick, landed, jump_fail,
        output jump_left, jump_right, busy, queue_count, overflow, timeout
    );
endinterface

// File: rtl/jump_scheduler.sv
// Queues left/right key presses in a two-entry FIFO and issues one jump at a time,
// waiting for the landing (or a miss / timeout) before the next jump is released.
module jump_scheduler #(
    parameter int unsigned LAND_TIMEOUT_MS = 1000,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    jump_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LAND = 2'd1,
        HALT      = 2'd2
    } state_e;

    localparam logic [1:0]  FULL    = 2'(QUEUE_DEPTH);
    localparam logic [11:0] LAST_MS = 12'(LAND_TIMEOUT_MS - 1);

    state_e      state_q;
    logic [1:0]  prev_key_q;
    logic        armed_q;      // a 00 sample has been seen since reset
    logic [1:0]  fifo_q;       // entry i direction, 1 = right; entry 0 is the head
    logic [1:0]  fifo_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [11:0] ms_q;
    logic        jump_left_q;
    logic        jump_right_q;
    logic        overflow_q;
    logic        timeout_q;

    logic press;
    logic pop;
    logic accept;
    logic push;
    logic drop;

    always_comb begin
        press  = armed_q && (prev_key_q == 2'b00) &&
                 ((bus.key_code == 2'b01) || (bus.key_code == 2'b10));
        pop    = bus.en && (state_q == IDLE) && (count_q != 2'd0);
        accept = press && bus.en && (state_q != HALT);
        push   = accept && ((count_q != FULL) || pop);
        drop   = accept && (count_q == FULL) && !pop;
    end

    // Pop shifts the head out first so a same-cycle push lands behind the survivor.
    always_comb begin
        // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
        fifo_d  = fifo_q;
        count_d = count_q;
        // NOTE: blocking '=' here because count_d is read back within this same block.
        if (pop) begin
            fifo_d  = {1'b0, fifo_q[1]};
            count_d = count_q - 2'd1;
        end
        if (push) begin
            fifo_d[count_d[0]] = bus.key_code[1];
            count_d            = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_key_q   <= 2'b00;
            armed_q      <= 1'b0;
            fifo_q       <= 2'b00;
            count_q      <= 2'd0;
            ms_q         <= 12'd0;
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= drop;
            prev_key_q   <= bus.key_code;
            if (bus.key_code == 2'b00) begin
                armed_q <= 1'b1;
            end
            fifo_q  <= fifo_d;
            count_q <= count_d;

            if (!bus.en) begin
                state_q <= IDLE;
                count_q <= 2'd0;
                ms_q    <= 12'd0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (pop) begin
                            state_q      <= WAIT_LAND;
                            ms_q         <= 12'd0;
                            jump_left_q  <= ~fifo_q[0];
                            jump_right_q <= fifo_q[0];
                        end
                    end
                    WAIT_LAND: begin
                        if (bus.jump_fail) begin
                            state_q <= HALT;
                            count_q <= 2'd0;
                        end else if (bus.landed) begin
                            state_q <= IDLE;
                        end else if (bus.one_ms_tick) begin
                            if (ms_q == LAST_MS) begin
                                timeout_q <= 1'b1;
                                state_q   <= HALT;
                                count_q   <= 2'd0;
                            end else begin
                                ms_q <= ms_q + 12'd1;
                            end
                        end
                    end
                    HALT: begin
                        // Parked until the game phase drops en.
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.jump_left   = jump_left_q;
    assign bus.jump_right  = jump_right_q;
    assign bus.busy        = (state_q == WAIT_LAND) || (state_q == HALT);
    assign bus.queue_count = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: doc/jump_scheduler.md
JUMP_SCHEDULER -- requirements
Module: jump_scheduler

Interface
REQ-001 Parameter LAND_TIMEOUT_MS, default 1000: max ms in WAIT_LAND before timeout; legal 1..4095.
REQ-002 Parameter QUEUE_DEPTH, fixed 2: pending-press FIFO depth.
REQ-003 clk  input  1  40 MHz system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  game-play phase active; 0 flushes and parks the block.
REQ-006 key_code  input  2  level code: 00 none, 01 left, 10 right, 11 up.
REQ-007 one_ms_tick  input  1  single-cycle pulse every 1 ms.
REQ-008 landed  input  1  single-cycle pulse: character finished a jump.
REQ-009 jump_fail  input  1  single-cycle pulse: jump missed a block.
REQ-010 jump_left  output  1  registered single-cycle jump command, left.
REQ-011 jump_right  output  1  registered single-cycle jump command, right.
REQ-012 busy  output  1  high in WAIT_LAND and HALT.
REQ-013 queue_count  output  2  entries in FIFO, 0..2.
REQ-014 overflow  output  1  single-cycle pulse: press dropped, FIFO full.
REQ-015 timeout  output  1  single-cycle pulse: no landed within LAND_TIMEOUT_MS.

Function
REQ-016 Press = key_code in {01,10} in cycle C while registered previous key_code was 00; 11 and held codes never push.
REQ-017 Press detected in cycle C SHALL be written to FIFO tail at end of C when en=1, state not HALT, queue_count<2.
REQ-018 Press with queue_count=2 and no pop in same cycle SHALL be dropped and overflow high in C+1.
REQ-019 Push and pop in same cycle: queue_count unchanged, FIFO order preserved.
REQ-020 States: IDLE, WAIT_LAND, HALT; reset state IDLE.
REQ-021 IDLE, en=1, queue_count>0: pop head, next state WAIT_LAND, matching jump_left/jump_right high exactly one cycle (cycle after decision); never both high.
REQ-022 Press into empty FIFO in IDLE at cycle C: pulse in cycle C+2.
REQ-023 Entering WAIT_LAND clears 12-bit ms counter; counter increments on each one_ms_tick in WAIT_LAND.
REQ-024 WAIT_LAND: landed -> IDLE; jump_fail -> HALT; counter reaching LAND_TIMEOUT_MS -> timeout pulse, HALT.
REQ-025 Priority same cycle: jump_fail > landed > timeout.
REQ-026 landed or jump_fail outside WAIT_LAND SHALL be ignored.
REQ-027 Entering HALT flushes FIFO (queue_count 0 next cycle); presses ignored in HALT.
REQ-028 HALT exits to IDLE only when en=0.
REQ-029 en=0 in any state: next state IDLE, FIFO flushed, counter cleared, no jump pulse issued; takes priority over all other transitions.
REQ-030 No new jump issued while in WAIT_LAND, regardless of FIFO contents.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, FIFO empty, counter 0, jump_left=0, jump_right=0, busy=0, queue_count=0, overflow=0, timeout=0, previous-key register 00.
REQ-032 rst asserted mid-WAIT_LAND SHALL discard the in-flight jump and pending entries; no pulse follows release.
REQ-033 First press after rst release SHALL require a 00 sample before it counts.

Verification
REQ-034 en=1, key 00->01 at C -> queue_count=1 at C+1, jump_left high only at C+2, busy=1 from C+2; landed -> busy=0 next cycle.
REQ-035 In WAIT_LAND press right, left, right -> queue_count 2, overflow one pulse on third press; after landed, jump_right issued next, then left after next landed.
REQ-036 LAND_TIMEOUT_MS=3, no landed -> timeout pulse after 3rd one_ms_tick, state HALT, queue_count 0; en=0 -> IDLE.
REQ-037 landed and jump_fail same cycle -> HALT, no timeout, FIFO flushed.
REQ-038 key held 01 for 100 cycles -> exactly one push; key 11 -> no push.
REQ-039 rst pulse while busy with queue_count=2 -> all outputs 0 immediately, no jump pulse for 10 cycles after release with key 00.
